sram_32x128_1rw: RTL and testbench



---
 rtl/sram_32x128_1rw.sv | 46 ++++
 tb/tb_sram_32x128_1rw.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sram_32x128_1rw.sv
// Single-port synchronous 32x128 SRAM with a registered read port.
// Define SRAM_WRITE_THROUGH_EN to make write data appear on dout0 at the write edge.
module sram_32x128_1rw #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // Array: no reset, so contents survive rst0_n; X on controls compares false and blocks the write.
  always_ff @(posedge clk0) begin
    if (rst0_n && (csb0 == 1'b0) && (web0 == 1'b0)) begin
      mem[addr0] <= din0;
    end
  end

  // Read data register
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout0 <= '0;
`ifndef SYNTHESIS
    end else if ($isunknown({csb0, web0})) begin
      dout0 <= 'x;
`endif
    end else if (!csb0) begin
      if (web0) begin
        dout0 <= mem[addr0];
      end
`ifdef SRAM_WRITE_THROUGH_EN
      else begin
        dout0 <= din0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_32x128_1rw.sv
// Self-checking bench for sram_32x128_1rw: directed vector table, reset sequence,
// then randomized traffic checked against an array-based reference model.
module tb_sram_32x128_1rw;

`ifdef SRAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        clk0;
  logic        rst0_n;
  logic        csb0;
  logic        web0;
  logic [6:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;

  int n_cmp = 0;
  int n_err = 0;

  sram_32x128_1rw dut (
    .clk0  (clk0),
    .rst0_n(rst0_n),
    .csb0  (csb0),
    .web0  (web0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (dout0)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  typedef struct {
    logic        csb;
    logic        web;
    logic [6:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] last_exp;

  // Reference model: plain storage plus the expected output word.
  logic [31:0] model_mem [128];
  bit          model_wr  [128];
  logic [31:0] model_dout;
  bit          model_known;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dout0 got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic w, input logic [6:0] a,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.csb = c; v.web = w; v.addr = a; v.din = d; v.exp = e;
    vecs.push_back(v);
    last_exp = e;
  endtask

  task automatic add_write(input logic [6:0] a, input logic [31:0] d);
    add(1'b0, 1'b0, a, d, WT ? d : last_exp);
  endtask

  task automatic apply(input logic c, input logic w, input logic [6:0] a, input logic [31:0] d);
    @(negedge clk0);
    csb0 = c; web0 = w; addr0 = a; din0 = d;
    @(posedge clk0);
    #1;
    if (!c) begin
      if (!w) begin
        model_mem[a] = d;
        model_wr[a]  = 1'b1;
        if (WT) begin
          model_dout  = d;
          model_known = 1'b1;
        end
      end else begin
        model_dout  = model_mem[a];
        model_known = model_wr[a];
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) model_wr[i] = 1'b0;
    csb0 = 1'b1; web0 = 1'b1; addr0 = '0; din0 = '0;
    rst0_n = 1'b0;
    #2;
    check("reset_state", dout0, 32'h0);
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    rst0_n = 1'b1;
    model_dout = 32'h0; model_known = 1'b1;

    // Directed vector table
    last_exp = 32'h0;
    add_write(7'd10, 32'hFACECAFE);
    add(1'b0, 1'b1, 7'd10, 32'h0, 32'hFACECAFE);
    add_write(7'h10, 32'hFACECAFE);
    for (int i = 0; i < 10; i++) add(1'b1, i[0], 7'(i * 13), 32'(i * 32'h01010101), last_exp);
    add(1'b0, 1'b1, 7'h10, 32'h0, 32'hFACECAFE);
    add_write(7'd0, 32'h00000001);
    add_write(7'd127, 32'hFFFFFFFF);
    add(1'b0, 1'b1, 7'd0, 32'h0, 32'h00000001);
    add(1'b0, 1'b1, 7'd127, 32'h0, 32'hFFFFFFFF);
    add(1'b1, 1'b0, 7'd10, 32'h12345678, 32'hFFFFFFFF);
    add(1'b0, 1'b1, 7'd10, 32'h0, 32'hFACECAFE);
    add_write(7'd5, 32'hA5A5A5A5);
    add(1'b0, 1'b1, 7'd5, 32'h0, 32'hA5A5A5A5);

    foreach (vecs[i]) begin
      apply(vecs[i].csb, vecs[i].web, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d", i), dout0, vecs[i].exp);
    end

    // Reset mid-stream: output clears immediately, access during reset is dropped, contents kept
    apply(1'b0, 1'b1, 7'd10, 32'h0);
    check("pre_reset_read", dout0, 32'hFACECAFE);
    #2;
    rst0_n = 1'b0;
    #1;
    check("reset_async_clear", dout0, 32'h0);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 7'd10; din0 = 32'hDEADBEEF;
    @(posedge clk0);
    #1;
    check("reset_hold", dout0, 32'h0);
    @(negedge clk0);
    csb0 = 1'b1; web0 = 1'b1;
    rst0_n = 1'b1;
    model_dout = 32'h0; model_known = 1'b1;
    apply(1'b0, 1'b1, 7'd10, 32'h0);
    check("post_reset_retained", dout0, 32'hFACECAFE);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic       c, w;
      logic [6:0] a;
      c = ($urandom_range(0, 3) == 0);
      w = $urandom_range(0, 1) != 0;
      a = (i < 200) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
      apply(c, w, a, $urandom);
      if (model_known) check($sformatf("rand%0d", i), dout0, model_dout);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
